// File: rtl/reg_read_port_pipe.sv
// ---------------------------------------------------------------------------
// reg_read_port_pipe
//
// Registered N-to-1 word selector for the register-file read path. One
// WIDTH-bit word is picked out of a flattened DEPTH-word bus when a request
// is accepted. The result (with same-cycle write forwarding, an optional
// hardwired zero register and out-of-range flagging) is returned through a
// 2-entry skid buffer. The result appears one cycle after acceptance, and
// back-to-back requests run at full throughput.
//
// Optional feature (compile-time macro): RDPORT_PARITY_EN
//   defined   -> adds o_out_par = ^o_out_data, registered with the data
//   undefined -> o_out_par and its logic do not exist
//
// Parameters
//   WIDTH     bits per word
//   DEPTH     number of selectable words (2..1024)
//   SEL_W     select width, 2**SEL_W >= DEPTH
//   ZERO_REG  1: select 0 always reads 0 and is never forwarded
//
// Ports
//   i_clock      rising-edge clock
//   i_reset      synchronous, active-high reset
//   i_in         word k = i_in[k*WIDTH +: WIDTH]
//   i_req_valid  request present
//   i_req_sel    word index
//   o_req_ready  request accepted when i_req_valid & o_req_ready
//   i_wr_en      register-file write happening this cycle
//   i_wr_sel     write index
//   i_wr_data    write data
//   o_out_valid  result present
//   o_out_data   selected word
//   o_out_err    result came from i_req_sel >= DEPTH
//   i_out_ready  result consumed when o_out_valid & i_out_ready
//   o_out_par    (RDPORT_PARITY_EN only) even parity of o_out_data
// ---------------------------------------------------------------------------
module reg_read_port_pipe #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int SEL_W    = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [DEPTH*WIDTH-1:0] i_in,
  input  logic                   i_req_valid,
  input  logic [SEL_W-1:0]       i_req_sel,
  output logic                   o_req_ready,
  input  logic                   i_wr_en,
  input  logic [SEL_W-1:0]       i_wr_sel,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic                   o_out_valid,
  output logic [WIDTH-1:0]       o_out_data,
  output logic                   o_out_err,
  input  logic                   i_out_ready
`ifdef RDPORT_PARITY_EN
  ,
  output logic                   o_out_par
`endif
);

  // Every encodable select value gets a slot; slots at or above DEPTH read
  // as zero so the lookup never indexes past the input bus.
  localparam int NSEL = 1 << SEL_W;
  localparam logic [SEL_W:0] DEPTH_W = (SEL_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  logic [WIDTH-1:0] w_words [NSEL];

  for (genvar gi = 0; gi < NSEL; gi++) begin : g_words
    if (gi < DEPTH) begin : g_live
      assign w_words[gi] = i_in[gi*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_words[gi] = '0;
    end
  end

  // Combinational lookup at acceptance time.
  logic             w_is_zero;
  logic             w_oor;
  logic             w_fwd;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;

  always_comb begin
    w_is_zero  = (ZERO_REG != 0) && (i_req_sel == '0);
    w_oor      = ({1'b0, i_req_sel} >= DEPTH_W);
    w_fwd      = i_wr_en && (i_wr_sel == i_req_sel);
    w_sel_data = '0;
    w_sel_err  = 1'b0;
    if (w_is_zero) begin
      w_sel_data = '0;
    end else if (w_oor) begin
      w_sel_data = '0;
      w_sel_err  = 1'b1;
    end else if (w_fwd) begin
      w_sel_data = i_wr_data;
    end else begin
      w_sel_data = w_words[i_req_sel];
    end
  end

  state_t           r_state;
  logic             r_req_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_head_data;
  logic             r_head_err;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;

  logic w_accept;
  logic w_pop;

  assign w_accept = i_req_valid && r_req_ready;
  assign w_pop    = r_out_valid && i_out_ready;

`ifdef RDPORT_PARITY_EN
  // Parity follows whatever word was captured, so the forwarded path
  // automatically carries parity of the write data.
  logic w_sel_par;
  logic r_head_par;
  logic r_skid_par;

  assign w_sel_par = ^w_sel_data;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_head_par <= 1'b0;
      r_skid_par <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_head_par <= w_sel_par;
        ST_ONE: begin
          if (w_accept && !w_pop) r_skid_par <= w_sel_par;
          else if (w_accept && w_pop) r_head_par <= w_sel_par;
        end
        ST_FULL: if (w_pop) r_head_par <= r_skid_par;
        default: ;
      endcase
    end
  end

  assign o_out_par = r_head_par;
`endif

  // Skid FSM. The head register always drives the outputs; the skid entry
  // only holds the second result while the consumer is stalled, so the
  // head is untouched (stable) whenever out_valid & !out_ready.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_EMPTY;
      r_req_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_head_data <= '0;
      r_head_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_head_data <= w_sel_data;
            r_head_err  <= w_sel_err;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_pop) begin
            r_skid_data <= w_sel_data;
            r_skid_err  <= w_sel_err;
            r_req_ready <= 1'b0;
            r_state     <= ST_FULL;
          end else if (w_accept && w_pop) begin
            r_head_data <= w_sel_data;
            r_head_err  <= w_sel_err;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // req_ready is low here, so nothing can be accepted.
          if (w_pop) begin
            r_head_data <= r_skid_data;
            r_head_err  <= r_skid_err;
            r_req_ready <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_req_ready <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_head_data;
  assign o_out_err   = r_head_err;

endmodule

// File: tb/tb_reg_read_port_pipe.sv
// ---------------------------------------------------------------------------
// tb_reg_read_port_pipe
//
// Self-checking bench for reg_read_port_pipe (WIDTH=32, DEPTH=24, SEL_W=5,
// ZERO_REG=1). The reference is a plain queue of expected results with a
// capacity of two: requests push the word chosen by the lookup priority
// rules, and consumer handshakes pop from the front. A compare process
// checks the DUT against the queue on every falling edge. Directed
// sequences with literal expectations pin the queue model, followed by a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_reg_read_port_pipe;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 24;
  localparam int SEL_W    = 5;
  localparam int ZERO_REG = 1;

  logic                   clk;
  logic                   rst;
  logic [DEPTH*WIDTH-1:0] in_bus;
  logic                   req_valid;
  logic [SEL_W-1:0]       req_sel;
  logic                   req_ready;
  logic                   wr_en;
  logic [SEL_W-1:0]       wr_sel;
  logic [WIDTH-1:0]       wr_data;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_err;
  logic                   out_ready;
`ifdef RDPORT_PARITY_EN
  logic                   out_par;
`endif

  logic [WIDTH-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  reg_read_port_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W), .ZERO_REG(ZERO_REG)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_in       (in_bus),
    .i_req_valid(req_valid),
    .i_req_sel  (req_sel),
    .o_req_ready(req_ready),
    .i_wr_en    (wr_en),
    .i_wr_sel   (wr_sel),
    .i_wr_data  (wr_data),
    .o_out_valid(out_valid),
    .o_out_data (out_data),
    .o_out_err  (out_err),
    .i_out_ready(out_ready)
`ifdef RDPORT_PARITY_EN
    ,
    .o_out_par  (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_bus = '0;
    for (int k = 0; k < DEPTH; k++) in_bus[k*WIDTH +: WIDTH] = mem[k];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [WIDTH-1:0] d;
    logic             e;
  } res_t;

  res_t q[$];
  bit   model_live = 0;

  function automatic res_t lookup(input int sel, input bit we, input int wsel,
                                  input logic [WIDTH-1:0] wdata);
    res_t r;
    r.d = '0;
    r.e = 1'b0;
    if (ZERO_REG != 0 && sel == 0) r.d = '0;
    else if (sel >= DEPTH) r.e = 1'b1;
    else if (we && wsel == sel) r.d = wdata;
    else r.d = mem[sel];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      model_live = 1;
    end else if (model_live) begin
      automatic int   sz  = q.size();
      automatic bit   acc = req_valid && (sz < 2);
      automatic bit   pp  = (sz > 0) && out_ready;
      automatic res_t e   = lookup(int'(req_sel), wr_en, int'(wr_sel), wr_data);
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      check("req_ready", {31'b0, req_ready}, {31'b0, q.size() < 2});
      if (q.size() > 0) begin
        check("out_data", out_data, q[0].d);
        check("out_err", {31'b0, out_err}, {31'b0, q[0].e});
`ifdef RDPORT_PARITY_EN
        check("out_par", {31'b0, out_par}, {31'b0, ^q[0].d});
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = '0; wr_en = 1'b0;
    wr_sel = '0; wr_data = '0; out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    mem[5] = 32'hDEADBEEF;
    step(); step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_data", out_data, 32'd0);
    check("rst_err", {31'b0, out_err}, 32'd0);
    rst = 1'b0;

    // single request, 1-cycle latency
    req_valid = 1'b1; req_sel = 5'd5;
    step();
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_data", out_data, 32'hDEADBEEF);

    // back-to-back at full throughput
    for (int k = 1; k <= 3; k++) begin
      req_sel = SEL_W'(k);
      step();
      check("t2_data", out_data, mem[k]);
      check("t2_ready", {31'b0, req_ready}, 32'd1);
    end
    req_valid = 1'b0;
    step();
    check("t2_drain", {31'b0, out_valid}, 32'd0);

    // backpressure: two accepts then stall
    out_ready = 1'b0; req_valid = 1'b1; req_sel = 5'd8;
    step();
    check("t3_ready1", {31'b0, req_ready}, 32'd1);
    req_sel = 5'd9;
    step();
    check("t3_ready2", {31'b0, req_ready}, 32'd0);
    check("t3_head", out_data, mem[8]);
    req_sel = 5'd10;
    step();
    check("t3_hold", out_data, mem[8]);
    check("t3_ready3", {31'b0, req_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check("t3_second", out_data, mem[9]);
    check("t3_ready4", {31'b0, req_ready}, 32'd1);
    step();
    check("t3_third", out_data, mem[10]);
    req_valid = 1'b0;
    step();

    // forwarding
    mem[7] = '0;
    req_valid = 1'b1; req_sel = 5'd7; wr_en = 1'b1; wr_sel = 5'd7; wr_data = 32'h12345678;
    step();
    check("t4_fwd", out_data, 32'h12345678);
    wr_sel = 5'd6;
    step();
    check("t4_nofwd", out_data, 32'd0);
    req_valid = 1'b0; wr_en = 1'b0;
    step();

    // zero register and out-of-range
    mem[0] = 32'hFFFFFFFF;
    req_valid = 1'b1; req_sel = 5'd0; wr_en = 1'b1; wr_sel = 5'd0; wr_data = 32'hAAAA5555;
    step();
    check("t5_zero", out_data, 32'd0);
    check("t5_zero_err", {31'b0, out_err}, 32'd0);
    wr_en = 1'b0; req_sel = 5'd30;
    step();
    check("t5_oor_data", out_data, 32'd0);
    check("t5_oor_err", {31'b0, out_err}, 32'd1);
    req_sel = 5'd24;
    step();
    check("t5_edge_err", {31'b0, out_err}, 32'd1);
    req_sel = 5'd23;
    step();
    check("t5_last_err", {31'b0, out_err}, 32'd0);
    check("t5_last_data", out_data, mem[23]);
    req_valid = 1'b0;
    step();

`ifdef RDPORT_PARITY_EN
    mem[3] = 32'h00000007;
    req_valid = 1'b1; req_sel = 5'd3;
    step();
    check("t6_par", {31'b0, out_par}, 32'd1);
    req_sel = 5'd4; wr_en = 1'b1; wr_sel = 5'd4; wr_data = 32'h00000003;
    step();
    check("t6_par_fwd", {31'b0, out_par}, 32'd0);
    req_valid = 1'b0; wr_en = 1'b0;
    step();
`endif

    // reset while FULL
    out_ready = 1'b0; req_valid = 1'b1; req_sel = 5'd1;
    step();
    req_sel = 5'd2;
    step();
    check("t6_full", {31'b0, req_ready}, 32'd0);
    rst = 1'b1; req_sel = 5'd3;
    step();
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    step();
    check("t6_no_stale", {31'b0, out_valid}, 32'd0);

    // randomized phase
    for (int c = 0; c < 2000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_sel   = SEL_W'($urandom_range(0, 31));
      wr_en     = ($urandom_range(0, 1) != 0);
      wr_sel    = ($urandom_range(0, 1) != 0) ? req_sel : SEL_W'($urandom_range(0, 31));
      wr_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, DEPTH - 1)] = $urandom;
      step();
    end
    rst = 1'b0; req_valid = 1'b0; wr_en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
